// File: rtl/jk_bank_arbiter_if.sv
// Request/command bus between NREQ requesters and the JK bank arbiter, plus the
// JK drive lines toward the flip-flop bank and a debug view of the arbiter FSM.
`timescale 1ns/1ps

interface jk_bank_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int NBITS = 8,
    parameter int AW    = 3
);
    // Handshake: a requester raises req[i] with cmd/addr valid and keeps req[i]
    // high until ack[i] pulses; cmd/addr are captured on the granting edge only.
    logic [NREQ-1:0]    req;
    logic [2*NREQ-1:0]  cmd;
    logic [AW*NREQ-1:0] addr;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    ack;
    logic               err;
    logic [NBITS-1:0]   jk_j;
    logic [NBITS-1:0]   jk_k;
    logic               busy;
    logic [1:0]         state_dbg;

    modport master (
        output req, cmd, addr,
        input  gnt, ack, err, jk_j, jk_k, busy, state_dbg
    );

    modport slave (
        input  req, cmd, addr,
        output gnt, ack, err, jk_j, jk_k, busy, state_dbg
    );
endinterface

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter/sequencer driving one JK flip-flop of a bank per 3-cycle slot.
// Optional JK_SHADOW_EN adds a shadow copy of the bank (q_shadow) and a conflict flag.
`timescale 1ns/1ps

module jk_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int NBITS = 8,
    parameter int AW    = 3
) (
    input  logic clock,
    input  logic rst,
    jk_bank_arbiter_if.slave bus
`ifdef JK_SHADOW_EN
    ,
    output logic [NBITS-1:0] q_shadow,
    output logic             conflict
`endif
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   sel;
    logic [AW-1:0]   lat_addr;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] ack_q;
    logic            err_q;
    logic [NBITS-1:0] jk_j_q;
    logic [NBITS-1:0] jk_k_q;
    logic            busy_q;
`ifdef JK_SHADOW_EN
    logic [1:0]      lat_cmd;
`endif

    logic            found;
    logic [PW-1:0]   pick;
    logic [1:0]      pick_cmd;
    logic [AW-1:0]   pick_addr;
    logic            pick_valid;
    logic            lat_valid;

    function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] s);
        logic [NREQ-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

    // First requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && bus.req[(int'(rr_ptr) + i) % NREQ]) begin
                found = 1'b1;
                pick  = PW'((int'(rr_ptr) + i) % NREQ);
            end
        end
        pick_cmd   = bus.cmd[2*int'(pick) +: 2];
        pick_addr  = bus.addr[AW*int'(pick) +: AW];
        pick_valid = int'(pick_addr) < NBITS;
        lat_valid  = int'(lat_addr) < NBITS;
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            sel      <= '0;
            lat_addr <= '0;
            gnt_q    <= '0;
            ack_q    <= '0;
            err_q    <= 1'b0;
            jk_j_q   <= '0;
            jk_k_q   <= '0;
            busy_q   <= 1'b0;
`ifdef JK_SHADOW_EN
            lat_cmd  <= 2'b00;
            q_shadow <= '0;
            conflict <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    ack_q <= '0;
                    err_q <= 1'b0;
                    if (found) begin
                        sel      <= pick;
                        lat_addr <= pick_addr;
`ifdef JK_SHADOW_EN
                        lat_cmd  <= pick_cmd;
`endif
                        gnt_q    <= onehot(pick);
                        jk_j_q   <= pick_valid ? (NBITS'(pick_cmd[1]) << pick_addr) : '0;
                        jk_k_q   <= pick_valid ? (NBITS'(pick_cmd[0]) << pick_addr) : '0;
                        busy_q   <= 1'b1;
                        state    <= APPLY;
                    end
                end
                APPLY: begin
                    gnt_q  <= '0;
                    jk_j_q <= '0;
                    jk_k_q <= '0;
                    ack_q  <= onehot(sel);
                    err_q  <= !lat_valid;
                    state  <= ACK;
`ifdef JK_SHADOW_EN
                    // Shadow bit changes on the same edge the real bank clocks in j/k.
                    if (lat_valid) begin
                        case (lat_cmd)
                            2'b01:   q_shadow[lat_addr] <= 1'b0;
                            2'b10:   q_shadow[lat_addr] <= 1'b1;
                            2'b11:   q_shadow[lat_addr] <= ~q_shadow[lat_addr];
                            default: q_shadow[lat_addr] <= q_shadow[lat_addr];
                        endcase
                    end
                    conflict <= lat_valid &&
                                ((lat_cmd == 2'b10 &&  q_shadow[lat_addr]) ||
                                 (lat_cmd == 2'b01 && !q_shadow[lat_addr]));
`endif
                end
                ACK: begin
                    ack_q  <= '0;
                    err_q  <= 1'b0;
                    busy_q <= 1'b0;
                    rr_ptr <= (sel == PW'(NREQ - 1)) ? '0 : sel + 1'b1;
                    state  <= IDLE;
`ifdef JK_SHADOW_EN
                    conflict <= 1'b0;
`endif
                end
                default: begin
                    gnt_q  <= '0;
                    ack_q  <= '0;
                    err_q  <= 1'b0;
                    jk_j_q <= '0;
                    jk_k_q <= '0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.ack       = ack_q;
    assign bus.err       = err_q;
    assign bus.jk_j      = jk_j_q;
    assign bus.jk_k      = jk_k_q;
    assign bus.busy      = busy_q;
    assign bus.state_dbg = state;
endmodule
